// File: rtl/pwm8_decoder.sv
// rtl/pwm8_decoder.sv - recovers an 8-bit duty value from a PWM waveform
module pwm8_decoder #(
    parameter int PERIOD  = 256,
    parameter int TOL     = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       PWM_sig,
    output logic [7:0] duty,
    output logic       vld,
    output logic       per_err,
    output logic       stuck
);

    localparam int PW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] P_LO  = PW'(PERIOD - TOL);
    localparam logic [PW-1:0] P_HI  = PW'(PERIOD + TOL);
    localparam logic [PW-1:0] P_MAX = PW'(TIMEOUT);
    localparam logic [PW-1:0] P_ONE = PW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           s1;
    logic           s2;
    logic           s3;
    logic [PW-1:0]  pcnt;
    logic [8:0]     hcnt;
    logic           to_done;
    logic           rise;
    logic           fall;
    logic           tmo_evt;
    logic           commit_ok;
    logic           commit_bad;

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // to_done keeps the timeout from re-firing while pcnt sits saturated
    always_comb begin
        state_nxt  = state;
        commit_ok  = 1'b0;
        commit_bad = 1'b0;
        tmo_evt    = (pcnt == P_MAX) && !to_done && !rise;
        case (state)
            IDLE: begin
                if (rise) state_nxt = HIGH;
            end
            HIGH: begin
                if (fall) state_nxt = LOW;
            end
            LOW: begin
                if (rise) begin
                    state_nxt = HIGH;
                    if (pcnt >= P_LO && pcnt <= P_HI) commit_ok = 1'b1;
                    else                               commit_bad = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (tmo_evt) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            pcnt    <= '0;
            hcnt    <= '0;
            to_done <= 1'b0;
            duty    <= 8'h00;
            vld     <= 1'b0;
            per_err <= 1'b0;
            stuck   <= 1'b0;
        end else begin
            state <= state_nxt;
            s1    <= PWM_sig;
            s2    <= s1;
            s3    <= s2;
            vld   <= 1'b0;

            if (rise) begin
                pcnt    <= P_ONE;
                hcnt    <= 9'd1;
                to_done <= 1'b0;
            end else begin
                if (pcnt != P_MAX) pcnt <= pcnt + P_ONE;
                if (state == HIGH && s2 && hcnt != 9'd511) hcnt <= hcnt + 9'd1;
                if (tmo_evt) to_done <= 1'b1;
            end

            if (commit_ok) begin
                duty    <= hcnt[8] ? 8'hFF : hcnt[7:0];
                vld     <= 1'b1;
                per_err <= 1'b0;
                stuck   <= 1'b0;
            end else if (commit_bad) begin
                per_err <= 1'b1;
            end else if (tmo_evt) begin
                stuck <= 1'b1;
                duty  <= {8{s2}};
                vld   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm8_decoder.sv
// tb/tb_pwm8_decoder.sv - randomized self-checking bench for pwm8_decoder
`timescale 1ps/1ps
module tb_pwm8_decoder;

    localparam int PERIOD  = 256;
    localparam int TOL     = 2;
    localparam int TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       PWM_sig = 1'b0;
    logic [7:0] duty;
    logic       vld;
    logic       per_err;
    logic       stuck;

    always #5000 clk = ~clk;

    pwm8_decoder #(.PERIOD(PERIOD), .TOL(TOL), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .PWM_sig (PWM_sig),
        .duty    (duty),
        .vld     (vld),
        .per_err (per_err),
        .stuck   (stuck)
    );

    int         total = 0;
    int         bad = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         exp_duty = 0;
    bit         exp_per_err = 0;
    bit         exp_stuck = 0;
    bit         have_prev = 0;
    int         prev_h = 0;
    int         prev_p = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (vld) got_q.push_back(duty);

    // a rising edge closes the previous frame (if one is open) and opens a new one
    task automatic model_rise(input int h, input int p);
        if (have_prev) begin
            if (prev_p >= PERIOD - TOL && prev_p <= PERIOD + TOL) begin
                exp_duty    = (prev_h > 255) ? 255 : prev_h;
                exp_q.push_back(8'(exp_duty));
                exp_per_err = 0;
                exp_stuck   = 0;
            end else begin
                exp_per_err = 1;
            end
        end
        have_prev = 1;
        prev_h    = h;
        prev_p    = p;
    endtask

    task automatic drive_frame(input int h, input int p);
        if (PWM_sig == 1'b0) model_rise(h, p);
        else                 have_prev = 0;
        PWM_sig = 1'b1;
        repeat (h) @(negedge clk);
        PWM_sig = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask

    task automatic hold(input bit level);
        if (level && !PWM_sig) model_rise(0, 0);
        exp_duty  = level ? 255 : 0;
        exp_q.push_back(8'(exp_duty));
        exp_stuck = 1;
        have_prev = 0;
        PWM_sig   = level;
        repeat (1100) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        int n;
        chk({tag, "_duty"}, duty, exp_duty);
        chk({tag, "_per_err"}, per_err, exp_per_err);
        chk({tag, "_stuck"}, stuck, exp_stuck);
        chk({tag, "_nvld"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_vld_duty"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int h;
        int p;
        int jit;

        repeat (3) @(negedge clk);
        chk("rst_duty", duty, 0);
        chk("rst_vld", vld, 0);
        chk("rst_per_err", per_err, 0);
        chk("rst_stuck", stuck, 0);
        rst_n = 1'b1;

        // 64/256 stream, with a latency probe on the second rise
        drive_frame(64, 256);
        model_rise(64, 256);
        PWM_sig = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("lat_edge2_vld", vld, 0);
        @(negedge clk);
        chk("lat_edge3_vld", vld, 1);
        repeat (61) @(negedge clk);
        PWM_sig = 1'b0;
        repeat (192) @(negedge clk);
        for (int i = 0; i < 3; i++) drive_frame(64, 256);
        check_state("t64");

        drive_frame(1, 256);
        drive_frame(255, 256);
        drive_frame(40, 256);
        check_state("h_edges");

        drive_frame(100, 250);
        drive_frame(100, 258);
        check_state("per250");
        drive_frame(100, 256);
        check_state("per258");

        hold(1'b0);
        check_state("stuck_low");
        drive_frame(128, 256);
        drive_frame(128, 256);
        hold(1'b1);
        check_state("stuck_high");
        for (int i = 0; i < 3; i++) drive_frame(128, 256);
        check_state("resume");

        for (int i = 0; i < 20; i++) begin
            p = int'($urandom_range(PERIOD + 4, PERIOD - 4));
            h = int'($urandom_range(PERIOD - 5, 1));
            drive_frame(h, p);
        end
        check_state("rand");

        // reset in the middle of a high phase
        drive_frame(200, 256);
        drive_frame(200, 256);
        model_rise(200, 256);
        PWM_sig = 1'b1;
        repeat (50) @(negedge clk);
        check_state("pre_rst");
        rst_n = 1'b0;
        #1;
        chk("midrst_duty", duty, 0);
        chk("midrst_vld", vld, 0);
        chk("midrst_per_err", per_err, 0);
        chk("midrst_stuck", stuck, 0);
        repeat (3) @(negedge clk);
        rst_n       = 1'b1;
        exp_duty    = 0;
        exp_per_err = 0;
        exp_stuck   = 0;
        have_prev   = 1;
        prev_h      = 150;
        prev_p      = 200;
        repeat (150) @(negedge clk);
        PWM_sig = 1'b0;
        repeat (56) @(negedge clk);
        for (int i = 0; i < 3; i++) drive_frame(200, 256);
        check_state("post_rst");

        // free-running source unrelated to clk phase, period jittered under one cycle
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        #(int'($urandom_range(9999, 1)));
        for (int i = 0; i < 8; i++) begin
            jit = int'($urandom_range(8000, 0)) - 4000;
            PWM_sig = 1'b1;
            #(1280000);
            PWM_sig = 1'b0;
            #(1280000 + jit);
        end
        #20000;
        chk("async_nvld", (got_q.size() >= 6) ? 1 : 0, 1);
        foreach (got_q[i]) chk("async_duty_in_127_129", (got_q[i] >= 127 && got_q[i] <= 129) ? 1 : 0, 1);
        chk("async_per_err", per_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
